// File: rtl/lea_key_schedule_if.sv
// Round-key stream from the LEA-128 key schedule to the round datapath.
interface lea_key_schedule_if;
    localparam int unsigned RK_W    = 192;
    localparam int unsigned ROUND_W = 5;

    logic               rk_valid;
    logic               rk_ready;
    logic [RK_W-1:0]    rk;
    logic [ROUND_W-1:0] rk_round;

    modport master (output rk_valid, output rk, output rk_round, input  rk_ready);
    modport slave  (input  rk_valid, input  rk, input  rk_round, output rk_ready);
endinterface

// File: rtl/lea_key_schedule.sv
// LEA-128 key schedule sequencer: walks the delta ROM, updates T0..T3 and
// streams 24 round keys over a valid/ready handshake.
module lea_key_schedule (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [127:0]  key_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [3:0]    delta_idx_o,
    input  logic [31:0]   delta_i,
    lea_key_schedule_if.master rk_if
);
    localparam int unsigned W        = 32;
    localparam int unsigned RK_W     = 192;
    localparam int unsigned ROUND_W  = 5;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(23);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         t0_q, t1_q, t2_q, t3_q;
    logic [W-1:0]         t0_d, t1_d, t2_d, t3_d;
    logic [ROUND_W-1:0]   i_q, i_d;
    logic [RK_W-1:0]      rk_q, rk_d;
    logic [ROUND_W-1:0]   rk_round_q, rk_round_d;
    logic                 rk_valid_q, rk_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [3:0]           delta_idx_q, delta_idx_d;

    logic [W-1:0]         d_c, nt0_c, nt1_c, nt2_c, nt3_c;
    logic                 fire_c, accept_c;

    // Rotate left by n (mod 32) via the upper half of a doubled word.
    function automatic logic [W-1:0] rol32(input logic [W-1:0] x, input logic [4:0] n);
        logic [2*W-1:0] tmp;
        tmp = {x, x} << n;
        return tmp[2*W-1:W];
    endfunction

    // Round datapath: ROM word rotated by round index, then the four word updates.
    always_comb begin
        d_c   = rol32(delta_i, i_q);
        nt0_c = rol32(t0_q + d_c,              5'd1);
        nt1_c = rol32(t1_q + rol32(d_c, 5'd1), 5'd3);
        nt2_c = rol32(t2_q + rol32(d_c, 5'd2), 5'd6);
        nt3_c = rol32(t3_q + rol32(d_c, 5'd3), 5'd11);
    end

    assign fire_c   = (state_q == RUN) && (!rk_valid_q || rk_if.rk_ready) && (i_q <= LAST_ROUND);
    assign accept_c = rk_valid_q && rk_if.rk_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        t3_d        = t3_q;
        i_d         = i_q;
        rk_d        = rk_q;
        rk_round_d  = rk_round_q;
        rk_valid_d  = rk_valid_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    t0_d    = key_i[31:0];
                    t1_d    = key_i[63:32];
                    t2_d    = key_i[95:64];
                    t3_d    = key_i[127:96];
                    i_d     = '0;
                end
            end
            RUN: begin
                if (fire_c) begin
                    t0_d       = nt0_c;
                    t1_d       = nt1_c;
                    t2_d       = nt2_c;
                    t3_d       = nt3_c;
                    rk_d       = {nt1_c, nt3_c, nt1_c, nt2_c, nt1_c, nt0_c};
                    rk_round_d = i_q;
                    rk_valid_d = 1'b1;
                    i_d        = i_q + ROUND_W'(1);
                end else if (accept_c) begin
                    rk_valid_d = 1'b0;
                end
                // Round 23 accepted: no fire is possible here since i is already 24.
                if (accept_c && (rk_round_q == LAST_ROUND)) begin
                    state_d    = DONE;
                    rk_valid_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        delta_idx_d = (state_d == RUN) ? {2'b00, i_d[1:0]} : 4'd0;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            t0_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            t3_q        <= '0;
            i_q         <= '0;
            rk_q        <= '0;
            rk_round_q  <= '0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            delta_idx_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            t3_q        <= t3_d;
            i_q         <= i_d;
            rk_q        <= rk_d;
            rk_round_q  <= rk_round_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            delta_idx_q <= delta_idx_d;
        end
    end

    assign rk_if.rk_valid = rk_valid_q;
    assign rk_if.rk       = rk_q;
    assign rk_if.rk_round = rk_round_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign delta_idx_o    = delta_idx_q;
endmodule

// File: tb/tb_lea_key_schedule.sv
// Directed bench for lea_key_schedule with a delta ROM and reference model.
module tb_lea_key_schedule;
    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [127:0] key_i;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   delta_idx_o;
    logic [31:0]  delta_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [191:0] mdl [24];
    logic [191:0] first_rk;

    lea_key_schedule_if rk_bus ();

    lea_key_schedule dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .key_i       (key_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .delta_idx_o (delta_idx_o),
        .delta_i     (delta_i),
        .rk_if       (rk_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delta constant ROM.
    always_comb begin
        case (delta_idx_o)
            4'd0:    delta_i = 32'hc3efe9db;
            4'd1:    delta_i = 32'h44626b02;
            4'd2:    delta_i = 32'h79e27c8a;
            4'd3:    delta_i = 32'h78df30ec;
            default: delta_i = 32'h0;
        endcase
    end

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    task automatic build_model(input logic [127:0] k);
        logic [31:0] t [4];
        logic [31:0] dl [4];
        int r [4];
        dl[0] = 32'hc3efe9db; dl[1] = 32'h44626b02; dl[2] = 32'h79e27c8a; dl[3] = 32'h78df30ec;
        r[0] = 1; r[1] = 3; r[2] = 6; r[3] = 11;
        for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 4; j++) t[j] = rol(t[j] + rol(dl[i % 4], i + j), r[j]);
            mdl[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
        end
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  192'(busy_o), 192'(0));
        chk({tag, "_valid"}, 192'(rk_bus.rk_valid), 192'(0));
        chk({tag, "_done"},  192'(done_o), 192'(0));
        chk({tag, "_rk"},    rk_bus.rk, 192'(0));
        chk({tag, "_round"}, 192'(rk_bus.rk_round), 192'(0));
        chk({tag, "_didx"},  192'(delta_idx_o), 192'(0));
    endtask

    // mode: 0 ready high, 1 stall at round 7, 2 random ready, 3 ignored start, 4 reset at round 10
    task automatic run_stream(input logic [127:0] k, input int mode);
        int n, last_hs, stall, done_cnt;
        logic have_hold, rdy;
        logic [191:0] h_rk;
        logic [4:0] h_rd;
        logic [3:0] h_di;
        build_model(k);
        start_i = 1'b1; key_i = k; rk_bus.rk_ready = 1'b1;
        tick();
        start_i = 1'b0; key_i = ~k;
        chk("start_busy",  192'(busy_o), 192'(1));
        chk("start_valid", 192'(rk_bus.rk_valid), 192'(0));
        chk("start_didx",  192'(delta_idx_o), 192'(0));
        n = 0; last_hs = -10; stall = 0; done_cnt = 0; have_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (have_hold) begin
                chk("hold_rk",    rk_bus.rk, h_rk);
                chk("hold_round", 192'(rk_bus.rk_round), 192'(h_rd));
                chk("hold_didx",  192'(delta_idx_o), 192'(h_di));
            end
            have_hold = 1'b0;
            if (c == 1) chk("first_valid", 192'(rk_bus.rk_valid), 192'(1));
            if (done_o) begin
                done_cnt++;
                chk("done_after_last", 192'(c), 192'(last_hs + 1));
                chk("done_count_hs",   192'(n), 192'(24));
                chk("done_valid_low",  192'(rk_bus.rk_valid), 192'(0));
                chk("done_busy",       192'(busy_o), 192'(1));
                break;
            end
            chk("run_busy", 192'(busy_o), 192'(1));
            rdy = 1'b1;
            if (mode == 2) rdy = 1'($urandom_range(0, 1));
            if (mode == 1 && rk_bus.rk_valid && rk_bus.rk_round == 5'd7 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end
            rk_bus.rk_ready = rdy;
            start_i = (mode == 3) && rk_bus.rk_valid && (rk_bus.rk_round == 5'd12);
            if (mode == 4 && rk_bus.rk_valid && rk_bus.rk_round == 5'd10) begin
                #3 rst_n = 1'b0;
                #1 chk_all_zero("async_rst");
                tick(); tick();
                rst_n = 1'b1;
                for (int w = 0; w < 5; w++) begin
                    tick();
                    chk("post_rst_valid", 192'(rk_bus.rk_valid), 192'(0));
                    chk("post_rst_busy",  192'(busy_o), 192'(0));
                end
                return;
            end
            if (rk_bus.rk_valid) begin
                chk("didx_seq", 192'(delta_idx_o), 192'((int'(rk_bus.rk_round) + 1) % 4));
                if (rdy) begin
                    chk("hs_round", 192'(rk_bus.rk_round), 192'(n));
                    if (n < 24) chk("hs_rk", rk_bus.rk, mdl[n]);
                    else chk("extra_hs", 192'(1), 192'(0));
                    if (n == 0) first_rk = rk_bus.rk;
                    n++;
                    last_hs = c;
                end else begin
                    have_hold = 1'b1;
                    h_rk = rk_bus.rk; h_rd = rk_bus.rk_round; h_di = delta_idx_o;
                end
            end
            tick();
        end
        start_i = 1'b0;
        if (done_cnt == 0) chk("timeout_done", 192'(0), 192'(1));
        if (mode == 1) chk("stall_cycles", 192'(stall), 192'(5));
        tick();
        chk("busy_fall", 192'(busy_o), 192'(0));
        chk("done_once", 192'(done_o), 192'(0));
        tick();
        chk("idle_rk_hold",    rk_bus.rk, mdl[23]);
        chk("idle_round_hold", 192'(rk_bus.rk_round), 192'(23));
        chk("idle_valid",      192'(rk_bus.rk_valid), 192'(0));
        chk("idle_didx",       192'(delta_idx_o), 192'(0));
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; key_i = '0; rk_bus.rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_no_valid", 192'(rk_bus.rk_valid), 192'(0));

        // Zero key with hand-computed round 0.
        run_stream(128'h0, 0);
        chk("zero_key_rk0", first_rk,
            192'h3efe9dbc_fa76f0fb_3efe9dbc_efe9dbc3_3efe9dbc_87dfd3b7);

        // Full stream, then backpressure and ignored start on the same key.
        run_stream(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 0);
        run_stream(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1);
        run_stream(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 3);

        // Random ready.
        run_stream(128'hdeadbeef_01234567_89abcdef_cafef00d, 2);

        // Reset mid-schedule, then a fresh schedule from scratch.
        run_stream(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 4);
        run_stream(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
